pe_result_collector: RTL
========================

Name: pe_result_collector

Overview:
- Drain-side companion to the PE_16in_top accumulator.
- Captures each accumulated FP64 result the PE presents on its result/out_en pair. The PE has no backpressure, so every strobe must be taken or explicitly dropped.
- Buffers captured results in a small FIFO and hands them downstream on a valid/ready stream framed into groups of frame_len words.
- Flags FP64 saturation (exp==0x7FF) and zero per word, and keeps overflow/drop statistics for debug.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
DW, 64, result width (FP64)
FLW, 8, width of frame_len

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
res_in  input  DW  PE result word
res_in_en  input  1  PE out_en strobe; one result per asserted cycle
flush  input  1  synchronous clear of FIFO and frame state
frame_len  input  FLW  words per output frame; 0 treated as 1
m_data  output  DW  head FP64 word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  head word is last of current frame
m_is_sat  output  1  head exponent == 11'h7FF
m_is_zero  output  1  head bits[62:0] == 0
level  output  log2(DEPTH)+1  current FIFO occupancy
ovf  output  1  sticky: a result was dropped
drop_cnt  output  8  dropped results, saturates at 255
result_cnt  output  16  accepted results, wraps

Behaviour:
- Reset (rstn==0 at clk edge): FIFO empty, so level=0 and m_valid=0. m_data=0, m_last=0, m_is_sat=0, m_is_zero=0, ovf=0, drop_cnt=0, result_cnt=0, frame index=0. Latched frame length = max(frame_len,1).
- Reset mid-stream discards all buffered words. No word is emitted after reset until a new res_in_en arrives.
- FIFO is first-word fall-through with registered pointers.
- Push at edge N (res_in_en=1, accepted) makes m_valid=1 at N+1 if the FIFO was empty. m_data, m_is_sat and m_is_zero come from the head entry.
- Pop occurs when m_valid && m_ready.
- Push acceptance: accepted iff level<DEPTH, or a pop happens in the same cycle.
  - Full with simultaneous pop: push accepted, level unchanged.
  - Simultaneous push+pop at any level: level unchanged, order preserved.
- Drop on full: res_in_en when full and no pop.
  - Word discarded, ovf<=1, drop_cnt increments unless already 255, result_cnt unchanged.
  - ovf clears only on reset.
- result_cnt increments by 1 per accepted push and wraps 0xFFFF->0.
- m_valid stays high while level>0 and is independent of m_ready. Holding m_ready=0 keeps m_data stable.
- Framing:
  - Frame index counts pops.
  - m_last = m_valid && (frame index == L-1), where L is the latched frame length.
  - On a pop with m_last: frame index <=0 and L <= max(frame_len,1).
  - Otherwise a pop increments frame index.
  - frame_len changes mid-frame take effect at the next frame boundary.
- flush:
  - FIFO emptied and frame index=0; L reloaded from frame_len next edge.
  - An in-cycle pop and push are both ignored. The push is not counted as a drop and does not set ovf.
  - result_cnt, drop_cnt and ovf are kept.
  - flush while rstn==0: reset wins.
- m_is_sat and m_is_zero are combinational from the head word and forced to 0 when m_valid=0.
- Sign bit is ignored for classification.

Test Plan:
- Single word: after reset, res_in=64'h3FF0000000000000 with res_in_en=1 for 1 cycle, m_ready=1 -> m_valid=1 for exactly one cycle, one edge after the push. Expect m_data=64'h3FF0000000000000, m_last=1 (frame_len=1), m_is_sat=0, result_cnt=1.
- Framing with backpressure: frame_len=3, push 6 words 1..6 at one per 3 cycles, m_ready toggling 1/0 -> output order 1..6. m_last high on words 3 and 6 only. m_data is stable while m_ready=0.
- Overflow: m_ready=0, DEPTH=8, 10 consecutive res_in_en -> level=8, ovf=1, drop_cnt=2, result_cnt=8. With m_ready=1 the drain yields the first 8 words in order.
- Full with simultaneous pop: FIFO full, m_ready=1 and res_in_en=1 for 4 cycles -> level stays 8, ovf unchanged, result_cnt+4, no loss of order.
- Classification: push 64'h7FF0000000000000, then 64'h8000000000000000, then 64'h4000000000000001 -> m_is_sat=1/0/0 and m_is_zero=0/1/0 respectively.
- Flush and reset mid-operation:
  - Flush: 5 words buffered, flush=1 with res_in_en=1 in the same cycle -> next edge level=0, m_valid=0, drop_cnt unchanged, result_cnt unchanged.
  - Reset: rstn=0 for one edge with 3 words buffered -> all outputs at reset values, result_cnt=0.

Source files
------------

// File: rtl/pe_result_collector.sv
// Drain-side collector for the PE accumulator: captures FP64 results, buffers them
// in a first-word fall-through FIFO and emits them on a framed valid/ready stream.
module pe_result_collector #(
   parameter int DEPTH = 8,
   parameter int DW    = 64,
   parameter int FLW   = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [DW-1:0]            res_in,
   input  logic                     res_in_en,
   input  logic                     flush,
   input  logic [FLW-1:0]           frame_len,
   output logic [DW-1:0]            m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic                     m_is_sat,
   output logic                     m_is_zero,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   output logic [7:0]               drop_cnt,
   output logic [15:0]              result_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [DW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [LW-1:0]  count;
   logic [FLW-1:0] frame_idx;
   logic [FLW-1:0] frame_len_q;
   logic [FLW-1:0] frame_len_eff;
   logic [DW-1:0]  head;

   logic full;
   logic pop_req;
   logic pop;
   logic push_ok;
   logic drop;

   // Stream handshake: a word transfers on any rising edge where m_valid && m_ready.
   // m_valid never waits on m_ready, and the head word holds until it transfers.
   assign full          = (count == FULL_LEVEL);
   assign m_valid       = (count != '0);
   assign pop_req       = m_valid && m_ready;
   assign pop           = pop_req && !flush;
   assign push_ok       = res_in_en && !flush && (!full || pop_req);
   assign drop          = res_in_en && !flush && full && !pop_req;
   assign frame_len_eff = (frame_len == '0) ? FLW'(1) : frame_len;

   assign head      = mem[rd_ptr];
   assign m_data    = m_valid ? head : '0;
   assign m_last    = m_valid && (frame_idx == frame_len_q - FLW'(1));
   // Classification ignores the sign bit so that -0 counts as zero and -Inf/NaN as saturated.
   assign m_is_sat  = m_valid && (head[62:52] == 11'h7FF);
   assign m_is_zero = m_valid && (head[62:0] == 63'd0);
   assign level     = count;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= res_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop) begin
            count <= count + LW'(1);
         end else if (pop && !push_ok) begin
            count <= count - LW'(1);
         end
      end
   end

   // The frame length is only sampled at a frame boundary so a frame never changes size mid-way.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         frame_idx   <= '0;
         frame_len_q <= frame_len_eff;
      end else if (pop) begin
         if (m_last) begin
            frame_idx   <= '0;
            frame_len_q <= frame_len_eff;
         end else begin
            frame_idx <= frame_idx + FLW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ovf        <= 1'b0;
         drop_cnt   <= '0;
         result_cnt <= '0;
      end else begin
         if (push_ok) begin
            result_cnt <= result_cnt + 16'd1;
         end
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule
